// File: rtl/aes128_encryptor.sv
// ---------------------------------------------------------------------------
// aes128_encryptor
//   Iterative AES-128 encryption core. One round runs per clock. The core
//   captures plaintext/key after reset and whenever either input changes,
//   and then runs ten rounds. It raises done when ciphertext holds the
//   encryption of the applied inputs.
//
// Ports
//   clk        in   1    system clock, rising edge active
//   rst        in   1    synchronous active-low reset (0 = reset)
//   plaintext  in   128  input block, bits 127..120 = AES byte 0
//   key        in   128  cipher key, bits 127..120 = key byte 0
//   ciphertext out  128  registered result, same byte order as inputs
//   done       out  1    registered, 1 = ciphertext matches current inputs
//
// Also contains aes128_sbox, the combinational FIPS-197 S-box.
// ---------------------------------------------------------------------------

module aes128_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  // Row-major FIPS-197 S-box. Entry 0 sits in the top byte.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry d occupies bits 2047-8d down to 2040-8d. The top index equals {~d, 3'b111}.
  assign sub = TABLE[{~data, 3'b111} -: 8];

endmodule

module aes128_encryptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         done
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm, fsm_next;
  logic         force_cap;
  logic [127:0] pt_q, key_q;
  logic [127:0] state, rk;
  logic [3:0]   round;

  logic         capture, last_round;
  logic [127:0] sub_bytes, shifted, mixed, round_out;
  logic [31:0]  rot_word, sub_word, key_t;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] rk_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // The state is column-major: byte 4c+r is row r of column c.
  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes128_sbox u_sbox (.data(state[127 - 8*i -: 8]), .sub(sub_bytes[127 - 8*i -: 8]));
  end

  // RotWord of the last key word feeds the four key-schedule S-boxes.
  assign rot_word = {rk[23:0], rk[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes128_sbox u_sbox (.data(rot_word[31 - 8*i -: 8]), .sub(sub_word[31 - 8*i -: 8]));
  end

  always_comb begin
    key_t     = sub_word ^ {rcon(round), 24'h000000};
    w0        = rk[127:96] ^ key_t;
    w1        = rk[95:64]  ^ w0;
    w2        = rk[63:32]  ^ w1;
    w3        = rk[31:0]   ^ w2;
    rk_next   = {w0, w1, w2, w3};
    shifted   = shift_rows(sub_bytes);
    mixed     = {mix_col(shifted[127:96]), mix_col(shifted[95:64]),
                 mix_col(shifted[63:32]),  mix_col(shifted[31:0])};
    round_out = ((round == 4'd10) ? shifted : mixed) ^ rk_next;
  end

  // A capture (forced or on an input change) takes priority over an
  // in-flight round, which makes a mid-run input change restart the job.
  always_comb begin
    fsm_next   = fsm;
    capture    = 1'b0;
    last_round = 1'b0;
    if ((fsm == IDLE && force_cap) || plaintext != pt_q || key != key_q) begin
      capture  = 1'b1;
      fsm_next = RUN;
    end else if (fsm == RUN && round == 4'd10) begin
      last_round = 1'b1;
      fsm_next   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) fsm <= IDLE;
    else      fsm <= fsm_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      force_cap  <= 1'b1;
      pt_q       <= '0;
      key_q      <= '0;
      state      <= '0;
      rk         <= '0;
      round      <= 4'd0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else if (capture) begin
      force_cap <= 1'b0;
      pt_q      <= plaintext;
      key_q     <= key;
      state     <= plaintext ^ key;
      rk        <= key;
      round     <= 4'd1;
      done      <= 1'b0;
    end else if (fsm == RUN) begin
      state <= round_out;
      rk    <= rk_next;
      round <= round + 4'd1;
      if (last_round) begin
        ciphertext <= round_out;
        done       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes128_encryptor.sv
// ---------------------------------------------------------------------------
// tb_aes128_encryptor
//   Self-checking bench for aes128_encryptor. It uses the FIPS-197 vectors
//   and random vectors. Expected ciphertexts come from a byte-array AES
//   model whose S-box is derived from the GF(2^8) inverse and the affine map.
// ---------------------------------------------------------------------------

module tb_aes128_encryptor;

  logic         clk;
  logic         rst;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         done;

  int tests;
  int failures;
  logic [7:0] sbox_tab [256];

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_encryptor dut (
    .clk(clk), .rst(rst), .plaintext(plaintext), .key(key),
    .ciphertext(ciphertext), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook AES-128: full 44-word key schedule, then ten rounds on a byte array.
  function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  temp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {sbox_tab[temp[23:16]], sbox_tab[temp[15:8]], sbox_tab[temp[7:0]], sbox_tab[temp[31:24]]}
               ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c + r] = sbox_tab[s[4*((c + r) % 4) + r]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k);
    plaintext = pt;
    key       = k;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] exp_ct, input logic exp_done);
    tests++;
    assert (ciphertext === exp_ct) else begin
      failures++;
      $error("[TB] FAIL %s ciphertext got %h expected %h", tag, ciphertext, exp_ct);
    end
    tests++;
    assert (done === exp_done) else begin
      failures++;
      $error("[TB] FAIL %s done got %b expected %b", tag, done, exp_done);
    end
  endtask

  // Ten edges with done low and ciphertext held, then the result on the 11th.
  task automatic runAndCheck(input string tag, input logic [127:0] exp_ct, input logic [127:0] held_ct);
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e < 11) checkOutput($sformatf("%s_e%0d", tag, e), held_ct, 1'b0);
      else        checkOutput($sformatf("%s_e%0d", tag, e), exp_ct, 1'b1);
    end
  endtask

  initial begin
    logic [127:0] rpt, rkey, last_ct;
    tests    = 0;
    failures = 0;
    rst      = 1'b0;
    applyStimulus(C1_PT, C1_KEY);
    buildSbox();

    // Reset holds outputs at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("reset_%0d", i), 128'h0, 1'b0);
    end

    // FIPS-197 C.1 from reset release.
    rst = 1'b1;
    runAndCheck("c1", C1_CT, 128'h0);

    // Input change while done: App. B vector.
    applyStimulus(B_PT, B_KEY);
    runAndCheck("appb", B_CT, C1_CT);

    // Static inputs keep the result.
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput($sformatf("hold_%0d", i), B_CT, 1'b1);
    end

    // Random vectors against the model.
    last_ct = B_CT;
    for (int v = 0; v < 4; v++) begin
      rpt  = rand128();
      rkey = rand128();
      applyStimulus(rpt, rkey);
      runAndCheck($sformatf("rand%0d", v), aesRef(rpt, rkey), last_ct);
      last_ct = aesRef(rpt, rkey);
    end

    // Abort: start C.1, switch to App. B after five edges.
    applyStimulus(C1_PT, C1_KEY);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput($sformatf("abort_pre_e%0d", e), last_ct, 1'b0);
    end
    applyStimulus(B_PT, B_KEY);
    runAndCheck("abort", B_CT, last_ct);

    // Mid-run reset: start C.1 and assert reset on edge 6.
    applyStimulus(C1_PT, C1_KEY);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput($sformatf("mrst_pre_e%0d", e), B_CT, 1'b0);
    end
    rst = 1'b0;
    tick();
    checkOutput("mrst_edge", 128'h0, 1'b0);
    rst = 1'b1;
    runAndCheck("mrst_rel", C1_CT, 128'h0);

    // Reset and input change on the same edge resolve to reset.
    rpt  = rand128();
    rkey = rand128();
    rst  = 1'b0;
    applyStimulus(rpt, rkey);
    tick();
    checkOutput("rst_and_chg", 128'h0, 1'b0);
    rst = 1'b1;
    runAndCheck("rst_and_chg_rel", aesRef(rpt, rkey), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/aes128_encryptor.md
# aes128_encryptor

Iterative AES-128 encryption core (FIPS-197, 10 rounds) that turns a 128-bit plaintext and a 128-bit cipher key into a 128-bit ciphertext. It has no start strobe. It captures its inputs automatically after reset and again whenever they change. It then runs one round per clock and flags the result with `done`. It sits between the crypt-architecture data path, which drives `plaintext` and `key` as static levels, and downstream logic that samples `ciphertext` while `done` is high.

## Interface
- Parameters: none. AES-128 only; round count fixed at 10.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset. Sampled on the `clk` rising edge; 0 = reset, 1 = run.
- `plaintext`  in  128  input block. Bit 127..120 is AES byte 0 (FIPS-197 `in0`).
- `key`  in  128  cipher key. Bit 127..120 is key byte 0.
- `ciphertext`  out  128  registered result, same byte order as the inputs.
- `done`  out  1  registered; 1 = `ciphertext` is the encryption of the currently applied `plaintext`/`key`.

## Operation
- Internal registers:
  - `pt_q`, `key_q`: captured inputs.
  - `state`: 128-bit round state.
  - `rk`: current round key.
  - `round`: 4-bit counter.
  - FSM: IDLE, RUN.
- Reset (`rst` = 0 at an edge):
  - `ciphertext` = 0, `done` = 0, `round` = 0, FSM = IDLE.
  - A capture is forced on the first run cycle after reset.
- Capture edge. Taken when the FSM is IDLE with the force flag set, or in any state when `plaintext` != `pt_q` or `key` != `key_q`:
  - `pt_q` ← `plaintext`, `key_q` ← `key`
  - `state` ← `plaintext ^ key`
  - `rk` ← `key`, `round` ← 1
  - `done` ← 0, FSM ← RUN
- RUN edge with `round` = r (1..10):
  - Derive `rk'` from `rk` with the standard expansion step: RotWord, SubWord, XOR with Rcon[r] (01,02,04,08,10,20,40,80,1b,36), then chained XOR of the words.
  - Rounds 1..9: `state` ← MixColumns(ShiftRows(SubBytes(state))) ^ `rk'`.
  - Round 10: MixColumns is omitted; the result is written to `ciphertext` as well as `state`, `done` ← 1, FSM ← IDLE.
  - `rk` ← `rk'`, `round` ← r+1.
- IDLE with no capture condition: all outputs hold. `done` stays 1 indefinitely.
- `ciphertext` keeps its previous value during RUN and changes only on the round-10 edge.
- S-box: a combinational 256-entry table (FIPS-197 Fig. 7), instantiated 16× for the state and 4× for the key schedule.
- MixColumns uses GF(2^8) xtime with reduction polynomial 0x11b.

## Timing
- Latency: if the capture happens on edge E0, rounds 1..10 run on E1..E10, so `ciphertext` and `done` = 1 become valid after E10. That is 11 edges including the capture.
- After `rst` rises, the first edge captures. `done` goes high 11 edges after `rst` is first sampled as 1.
- Input change mid-RUN: the computation aborts and restarts from the capture edge with the new values. `done` stays 0 and `ciphertext` keeps its old value.
- Input change while `done` = 1: `done` drops on the next edge (the capture edge).
- Reset asserted mid-RUN: it wins over everything on that edge and all outputs go to their reset values. Asserting reset and changing inputs on the same edge also resolves to reset.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst` = 0 for 3 edges → `ciphertext` = 0 and `done` = 0 on every edge.
- FIPS-197 C.1 vector:
  - Stimulus: `plaintext` = 00112233445566778899aabbccddeeff, `key` = 000102030405060708090a0b0c0d0e0f, release `rst`.
  - Response: after 11 edges `ciphertext` = 69c4e0d86a7b0430d8cdb78070b4c55a and `done` = 1. `done` must be 0 on edges 1..10.
- FIPS-197 App. B vector:
  - Stimulus: change inputs to `plaintext` = 3243f6a8885a308d313198a2e0370734, `key` = 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: `done` drops on the next edge and `ciphertext` holds 69c4…c55a until 11 edges later, when it becomes 3925841d02dc09fbdc118597196a0b32 with `done` = 1.
- Abort:
  - Stimulus: start the C.1 vector, then switch to the App. B inputs at edge 5 of RUN.
  - Response: exactly 11 edges after the switch, `ciphertext` = 3925841d…0b32. The C.1 result is never output.
- Mid-run reset: start C.1 and pull `rst` low at edge 6 → on that edge `ciphertext` = 0 and `done` = 0. After release, the C.1 result appears 11 edges later.
- Hold:
  - Stimulus: keep the inputs static for 50 edges after `done`.
  - Response: `done` stays 1 and `ciphertext` is unchanged.
